// File: rtl/booth_seq.sv
// Control sequencer for a radix-2 Booth multiplier datapath.
// Walks LOAD -> (EVAL, SHIFT) x WIDTH -> DONE and decodes the datapath strobes.
module booth_seq #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             c1,
    input  logic             c2,
    output logic             ld_m,
    output logic             ld_q,
    output logic             clr_a,
    output logic             alu_en,
    output logic             alu_sub,
    output logic             shift,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] count
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        EVAL  = 3'd2,
        SHIFT = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t           state, state_nx;
    logic [CNT_W-1:0] count_nx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            count <= '0;
        end else begin
            state <= state_nx;
            count <= count_nx;
        end
    end

    // Outputs decode from the registered state only, except the EVAL
    // add/sub strobes which follow the live {Q0,Q-1} pair.
    always_comb begin
        state_nx = IDLE;
        count_nx = count;
        ld_m     = 1'b0;
        ld_q     = 1'b0;
        clr_a    = 1'b0;
        alu_en   = 1'b0;
        alu_sub  = 1'b0;
        shift    = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        case (state)
            IDLE: begin
                state_nx = start ? LOAD : IDLE;
            end
            LOAD: begin
                ld_m     = 1'b1;
                ld_q     = 1'b1;
                clr_a    = 1'b1;
                busy     = 1'b1;
                count_nx = CNT_W'(WIDTH);
                state_nx = EVAL;
            end
            EVAL: begin
                busy     = 1'b1;
                state_nx = SHIFT;
                case ({c1, c2})
                    2'b10: begin
                        alu_en  = 1'b1;
                        alu_sub = 1'b1;
                    end
                    2'b01: alu_en = 1'b1;
                    default: ;
                endcase
            end
            SHIFT: begin
                shift    = 1'b1;
                busy     = 1'b1;
                count_nx = count - CNT_W'(1);
                state_nx = (count == CNT_W'(1)) ? DONE : EVAL;
            end
            DONE: begin
                done     = 1'b1;
                count_nx = '0;
                state_nx = IDLE;
            end
            default: begin
                // Illegal encodings fall back to IDLE on the next edge.
                count_nx = '0;
                state_nx = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_booth_seq.sv
// Bench for booth_seq: a WIDTH=4 instance for control timing and a WIDTH=8
// instance driving a behavioural Booth datapath for product checks.
module tb_booth_seq;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // ---------------- WIDTH=4 instance ----------------
    logic       start4;
    logic [1:0] c4;
    logic       ld_m4, ld_q4, clr_a4, alu_en4, alu_sub4, shift4, busy4, done4;
    logic [2:0] count4;
    logic [7:0] obs4;
    assign obs4 = {ld_m4, ld_q4, clr_a4, alu_en4, alu_sub4, shift4, busy4, done4};

    booth_seq #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .c1(c4[1]), .c2(c4[0]),
        .ld_m(ld_m4), .ld_q(ld_q4), .clr_a(clr_a4), .alu_en(alu_en4),
        .alu_sub(alu_sub4), .shift(shift4), .busy(busy4), .done(done4),
        .count(count4)
    );

    // ---------------- WIDTH=8 instance + datapath ----------------
    logic              start8;
    logic              ld_m8, ld_q8, clr_a8, alu_en8, alu_sub8, shift8, busy8, done8;
    logic [3:0]        count8;
    logic signed [7:0] a_op, b_op;
    logic [8:0]        acc;
    logic [7:0]        mq, mm;
    logic              qm1;

    booth_seq #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .c1(mq[0]), .c2(qm1),
        .ld_m(ld_m8), .ld_q(ld_q8), .clr_a(clr_a8), .alu_en(alu_en8),
        .alu_sub(alu_sub8), .shift(shift8), .busy(busy8), .done(done8),
        .count(count8)
    );

    // Accumulator carries a guard bit so a -128 multiplicand cannot overflow.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0; mq <= '0; mm <= '0; qm1 <= 1'b0;
        end else begin
            if (ld_m8) mm <= a_op;
            if (ld_q8) begin mq <= b_op; qm1 <= 1'b0; end
            if (clr_a8) acc <= '0;
            if (alu_en8) acc <= alu_sub8 ? acc - {mm[7], mm} : acc + {mm[7], mm};
            if (shift8) {acc, mq, qm1} <= {acc[8], acc, mq};
        end
    end

    // Expected strobes k cycles after the start edge (k=1 is LOAD), from the
    // cycle schedule: LOAD, then EVAL on even / SHIFT on odd cycles, then DONE.
    function automatic logic [7:0] exp_out(int k, int w, logic [1:0] c);
        if (k == 1) return 8'b1110_0010;
        if (k >= 2 && k <= 2*w + 1) begin
            if (k % 2 == 1) return 8'b0000_0110;
            if (c == 2'b10) return 8'b0001_1010;
            if (c == 2'b01) return 8'b0001_0010;
            return 8'b0000_0010;
        end
        if (k == 2*w + 2) return 8'b0000_0001;
        return 8'b0;
    endfunction

    function automatic int exp_count(int k, int w);
        if (k >= 2 && k <= 2*w + 1) return w - (k - 2) / 2;
        return 0;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; start4 = 1'b0; start8 = 1'b0; c4 = 2'b00;
        #1;
        total++;
        if (obs4 !== 8'b0 || count4 !== 3'd0) begin
            bad++; $display("FAIL reset_state: obs=%b cnt=%0d want 0/0", obs4, count4);
        end
        @(negedge clk) rst_n = 1'b1;
        start4 = 1'b1;
        @(posedge clk); #1; start4 = 1'b0;
        @(posedge clk); #1; c4 = 2'b10; #1;
        total++;
        if (obs4 !== 8'b0001_1010) begin
            bad++; $display("FAIL reset_pre_eval: obs=%b want 00011010", obs4);
        end
        #1 rst_n = 1'b0; #1;
        total++;
        if (obs4 !== 8'b0 || count4 !== 3'd0) begin
            bad++; $display("FAIL reset_async: obs=%b cnt=%0d want 0/0", obs4, count4);
        end
        @(posedge clk); #1;
        @(negedge clk) rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            total++;
            if (obs4 !== 8'b0 || busy4 !== 1'b0) begin
                bad++; $display("FAIL reset_release: obs=%b want 0", obs4);
            end
        end
    endtask

    task automatic test_pattern();
        logic [1:0] pat [4] = '{2'b00, 2'b10, 2'b11, 2'b01};
        logic [1:0] c;
        int shifts = 0;
        start4 = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk); #1;
            if (k == 1) start4 = 1'b0;
            c = (k >= 2 && k <= 9 && k % 2 == 0) ? pat[(k-2)/2] : 2'b00;
            c4 = c; #1;
            if (shift4 === 1'b1) shifts++;
            total++;
            if (obs4 !== exp_out(k, 4, c) || count4 !== 3'(exp_count(k, 4))) begin
                bad++; $display("FAIL pattern k=%0d: obs=%b cnt=%0d want %b/%0d",
                                k, obs4, count4, exp_out(k, 4, c), exp_count(k, 4));
            end
        end
        total++;
        if (shifts != 4) begin
            bad++; $display("FAIL pattern_shifts: got %0d want 4", shifts);
        end
    endtask

    task automatic test_all_sub();
        int seq [$];
        int want [$] = '{4, 3, 2, 1, 0};
        start4 = 1'b1;
        for (int k = 1; k <= 11; k++) begin
            @(posedge clk); #1;
            if (k == 1) start4 = 1'b0;
            c4 = 2'b10; #1;
            if (k >= 2 && (k % 2 == 0)) seq.push_back(int'(count4));
            total++;
            if (obs4 !== exp_out(k, 4, 2'b10) || count4 !== 3'(exp_count(k, 4))) begin
                bad++; $display("FAIL all_sub k=%0d: obs=%b cnt=%0d want %b/%0d",
                                k, obs4, count4, exp_out(k, 4, 2'b10), exp_count(k, 4));
            end
        end
        total++;
        if (seq != want) begin
            bad++; $display("FAIL all_sub_count_seq: got %p want %p", seq, want);
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0] c;
        int dones = 0, loads = 0, kk;
        start4 = 1'b1;
        for (int k = 1; k <= 23; k++) begin
            @(posedge clk); #1;
            c = 2'($urandom); c4 = c; #1;
            kk = (k >= 12) ? k - 11 : k;
            if (done4 === 1'b1) dones++;
            if (ld_m4 === 1'b1) loads++;
            total++;
            if (obs4 !== exp_out(kk, 4, c) || count4 !== 3'(exp_count(kk, 4))) begin
                bad++; $display("FAIL back_to_back k=%0d: obs=%b cnt=%0d want %b/%0d",
                                k, obs4, count4, exp_out(kk, 4, c), exp_count(kk, 4));
            end
            if (k == 21) start4 = 1'b0;
        end
        total++;
        if (dones != 2 || loads != 2) begin
            bad++; $display("FAIL back_to_back_counts: dones=%0d loads=%0d want 2/2", dones, loads);
        end
    endtask

    task automatic test_start_ignored();
        logic [1:0] c;
        int dones = 0;
        start4 = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            @(posedge clk); #1;
            start4 = (k == 3);
            c = 2'($urandom); c4 = c; #1;
            if (done4 === 1'b1) dones++;
            total++;
            if (obs4 !== exp_out(k, 4, c) || count4 !== 3'(exp_count(k, 4))) begin
                bad++; $display("FAIL start_ignored k=%0d: obs=%b cnt=%0d want %b/%0d",
                                k, obs4, count4, exp_out(k, 4, c), exp_count(k, 4));
            end
        end
        total++;
        if (dones != 1) begin
            bad++; $display("FAIL start_ignored_dones: got %0d want 1", dones);
        end
    endtask

    task automatic test_products();
        logic signed [7:0]  corner_a [6] = '{-8'sd128, -8'sd128, 8'sd127, 8'sd0, -8'sd1, 8'sd127};
        logic signed [7:0]  corner_b [6] = '{-8'sd128, 8'sd127, 8'sd127, -8'sd77, -8'sd1, -8'sd128};
        logic signed [15:0] want;
        int cyc;
        for (int i = 0; i < 1000; i++) begin
            if (i < 6) begin a_op = corner_a[i]; b_op = corner_b[i]; end
            else begin a_op = 8'($urandom); b_op = 8'($urandom); end
            want = a_op * b_op;
            start8 = 1'b1;
            @(posedge clk); #1; start8 = 1'b0;
            cyc = 0;
            while (done8 !== 1'b1 && cyc < 40) begin
                @(posedge clk); #1; cyc++;
            end
            total++;
            if (done8 !== 1'b1) begin
                bad++; $display("FAIL product_timeout i=%0d: no done within 40 cycles", i);
            end else if ({acc[7:0], mq} !== want) begin
                bad++; $display("FAIL product i=%0d a=%0d b=%0d: got %0d want %0d",
                                i, a_op, b_op, $signed({acc[7:0], mq}), want);
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        a_op = '0; b_op = '0;
        test_reset();
        test_pattern();
        test_all_sub();
        test_back_to_back();
        test_start_ignored();
        test_products();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
